// File: rtl/block_window_scheduler_if.sv
// Handshake bundle between the fetch/completion side (master) and the block window scheduler (slave).
// Carries allocation, completion events, branch resolution, commit handshake and window status.
interface block_window_scheduler_if #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int CNT_W     = 6
);
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [CNT_W-1:0]     alloc_store_cnt;
  logic [CNT_W-1:0]     alloc_write_cnt;
  logic [SLOT_W-1:0]    alloc_slot;
  logic                 store_done_valid;
  logic [SLOT_W-1:0]    store_done_slot;
  logic                 write_done_valid;
  logic [SLOT_W-1:0]    write_done_slot;
  logic                 branch_valid;
  logic [SLOT_W-1:0]    branch_slot;
  logic                 branch_mispredict;
  logic                 commit_valid;
  logic                 commit_ready;
  logic [SLOT_W-1:0]    commit_slot;
  logic                 flush_valid;
  logic [NUM_SLOTS-1:0] flush_mask;
  logic [NUM_SLOTS-1:0] inflight_mask;
  logic [SLOT_W:0]      occupancy;

  modport master (
    output alloc_valid, alloc_store_cnt, alloc_write_cnt,
    output store_done_valid, store_done_slot, write_done_valid, write_done_slot,
    output branch_valid, branch_slot, branch_mispredict, commit_ready,
    input  alloc_ready, alloc_slot, commit_valid, commit_slot,
    input  flush_valid, flush_mask, inflight_mask, occupancy
  );

  modport slave (
    input  alloc_valid, alloc_store_cnt, alloc_write_cnt,
    input  store_done_valid, store_done_slot, write_done_valid, write_done_slot,
    input  branch_valid, branch_slot, branch_mispredict, commit_ready,
    output alloc_ready, alloc_slot, commit_valid, commit_slot,
    output flush_valid, flush_mask, inflight_mask, occupancy
  );
endinterface

// File: rtl/block_window_scheduler.sv
// In-order window of in-flight blocks: allocate, track outstanding outputs, commit oldest, flush on mispredict.
// Optional performance counters enabled with `define BLOCK_WINDOW_PERF_EN.
module block_window_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int CNT_W     = 6
) (
  input  logic clk,
  input  logic rst_n,
  block_window_scheduler_if.slave bus
`ifdef BLOCK_WINDOW_PERF_EN
  ,
  output logic [31:0] perf_commits,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_squashed
`endif
);

  localparam logic [SLOT_W:0] FULL_CNT = (SLOT_W+1)'(NUM_SLOTS);

  logic [SLOT_W-1:0]    head_q, head_d;
  logic [SLOT_W-1:0]    tail_q, tail_d;
  logic [SLOT_W:0]      count_q, count_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] br_seen_q, br_seen_d;
  logic [CNT_W-1:0]     stores_q [NUM_SLOTS];
  logic [CNT_W-1:0]     stores_d [NUM_SLOTS];
  logic [CNT_W-1:0]     writes_q [NUM_SLOTS];
  logic [CNT_W-1:0]     writes_d [NUM_SLOTS];
  logic                 flush_valid_q, flush_valid_d;
  logic [NUM_SLOTS-1:0] flush_mask_q, flush_mask_d;

  logic                 alloc_fire;
  logic                 commit_ok;
  logic                 commit_fire;
  logic                 mispredict;
  logic [SLOT_W-1:0]    br_age;
  logic [NUM_SLOTS-1:0] squash;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  // Position of a slot counted from the oldest block; modulo wrap comes from the slot width.
  function automatic logic [SLOT_W-1:0] age_of(input logic [SLOT_W-1:0] slot,
                                               input logic [SLOT_W-1:0] head);
    return slot - head;
  endfunction

  assign bus.alloc_ready   = (count_q < FULL_CNT) && !(bus.branch_valid && bus.branch_mispredict);
  assign alloc_fire        = bus.alloc_valid && bus.alloc_ready;
  assign commit_ok         = valid_q[head_q] && (stores_q[head_q] == '0) &&
                             (writes_q[head_q] == '0) && br_seen_q[head_q];
  assign commit_fire       = commit_ok && bus.commit_ready;
  assign mispredict        = bus.branch_valid && bus.branch_mispredict && valid_q[bus.branch_slot];
  assign br_age            = age_of(bus.branch_slot, head_q);

  assign bus.alloc_slot    = tail_q;
  assign bus.commit_valid  = commit_ok;
  assign bus.commit_slot   = head_q;
  assign bus.flush_valid   = flush_valid_q;
  assign bus.flush_mask    = flush_mask_q;
  assign bus.inflight_mask = valid_q;
  assign bus.occupancy     = count_q;

  always_comb begin
    squash = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (mispredict && valid_q[i] && (age_of(SLOT_W'(i), head_q) > br_age)) begin
        squash[i] = 1'b1;
      end
    end
  end

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + (SLOT_W+1)'(alloc_fire) - (SLOT_W+1)'(commit_fire);
    valid_d       = valid_q;
    br_seen_d     = br_seen_q;
    stores_d      = stores_q;
    writes_d      = writes_q;
    flush_valid_d = mispredict;
    flush_mask_d  = squash;

    // Completion events land only on live slots that survive this cycle's flush.
    if (bus.store_done_valid && valid_q[bus.store_done_slot] && !squash[bus.store_done_slot]) begin
      stores_d[bus.store_done_slot] = sat_dec(stores_q[bus.store_done_slot]);
    end
    if (bus.write_done_valid && valid_q[bus.write_done_slot] && !squash[bus.write_done_slot]) begin
      writes_d[bus.write_done_slot] = sat_dec(writes_q[bus.write_done_slot]);
    end
    if (bus.branch_valid && valid_q[bus.branch_slot]) begin
      br_seen_d[bus.branch_slot] = 1'b1;
    end

    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + SLOT_W'(1);
    end

    if (alloc_fire) begin
      valid_d[tail_q]   = 1'b1;
      br_seen_d[tail_q] = 1'b0;
      stores_d[tail_q]  = bus.alloc_store_cnt;
      writes_d[tail_q]  = bus.alloc_write_cnt;
      tail_d            = tail_q + SLOT_W'(1);
    end

    // Allocation is blocked during a mispredict, so the surviving window ends at the branch slot.
    if (mispredict) begin
      valid_d = valid_d & ~squash;
      tail_d  = bus.branch_slot + SLOT_W'(1);
      count_d = (SLOT_W+1)'(br_age) + (SLOT_W+1)'(1) - (SLOT_W+1)'(commit_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      br_seen_q     <= '0;
      flush_valid_q <= 1'b0;
      flush_mask_q  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stores_q[i] <= '0;
        writes_q[i] <= '0;
      end
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      br_seen_q     <= br_seen_d;
      flush_valid_q <= flush_valid_d;
      flush_mask_q  <= flush_mask_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        stores_q[i] <= stores_d[i];
        writes_q[i] <= writes_d[i];
      end
    end
  end

`ifdef BLOCK_WINDOW_PERF_EN
  logic [31:0] perf_commits_q, perf_commits_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;

  function automatic logic [31:0] popcount(input logic [NUM_SLOTS-1:0] m);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUM_SLOTS; i++) n = n + 32'(m[i]);
    return n;
  endfunction

  always_comb begin
    perf_commits_d  = perf_commits_q + 32'(commit_fire);
    perf_flushes_d  = perf_flushes_q + 32'(mispredict);
    perf_squashed_d = perf_squashed_q;
    if (flush_valid_q) perf_squashed_d = perf_squashed_q + popcount(flush_mask_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_commits_q  <= '0;
      perf_flushes_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_commits_q  <= perf_commits_d;
      perf_flushes_q  <= perf_flushes_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_commits  = perf_commits_q;
  assign perf_flushes  = perf_flushes_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule
